// File: rtl/xup_tri_bus_pkg.sv
// Shared state encodings and a constant clog2 helper for the tri-state bus arbiter.
package xup_tri_bus_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/xup_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_owner, with wrap.
module xup_rr_pick
    import xup_tri_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_owner,
    output logic               any,
    output logic [IDW-1:0]     pick_idx,
    output logic [NUM_REQ-1:0] pick_onehot
);

    // last_owner itself is visited last, so it only wins when nobody else asks.
    always_comb begin
        any         = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!any && req[IDW'((32'(last_owner) + k) % NUM_REQ)]) begin
                any         = 1'b1;
                pick_idx    = IDW'((32'(last_owner) + k) % NUM_REQ);
                pick_onehot[IDW'((32'(last_owner) + k) % NUM_REQ)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xup_tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with hold timeout and a turnaround gap
// between owners, so two driver enables never overlap.
module xup_tri_bus_arbiter
    import xup_tri_bus_pkg::*;
#(
    parameter int unsigned  NUM_REQ     = 4,
    parameter int unsigned  MAX_HOLD    = 16,
    parameter int unsigned  TURN_CYCLES = 1,
    localparam int unsigned IDW         = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     owner,
    output logic               busy,
    output logic               timeout
);

    localparam int unsigned HW = clog2(MAX_HOLD);
    localparam int unsigned TW = clog2(TURN_CYCLES + 1);

    logic [1:0]         state_q,      state_d;
    logic [NUM_REQ-1:0] grant_q,      grant_d;
    logic [IDW-1:0]     owner_q,      owner_d;
    logic               busy_q,       busy_d;
    logic               timeout_q,    timeout_d;
    logic [HW-1:0]      hold_cnt_q,   hold_cnt_d;
    logic [TW-1:0]      turn_cnt_q,   turn_cnt_d;
    logic [IDW-1:0]     last_owner_q, last_owner_d;

    logic               pick_any;
    logic [IDW-1:0]     pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    xup_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req         (req),
        .last_owner  (last_owner_q),
        .any         (pick_any),
        .pick_idx    (pick_idx),
        .pick_onehot (pick_onehot)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        timeout_d    = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        turn_cnt_d   = turn_cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    grant_d    = pick_onehot;
                    owner_d    = pick_idx;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                // A release on the timeout edge wins, so timeout only fires while req is held.
                if (!req[owner_q] || (hold_cnt_q == HW'(MAX_HOLD - 1))) begin
                    state_d      = TURN;
                    grant_d      = '0;
                    owner_d      = '0;
                    busy_d       = 1'b0;
                    timeout_d    = req[owner_q];
                    last_owner_d = owner_q;
                    turn_cnt_d   = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            TURN: begin
                if (turn_cnt_q == TW'(TURN_CYCLES - 1)) begin
                    if (pick_any) begin
                        state_d    = GRANT;
                        grant_d    = pick_onehot;
                        owner_d    = pick_idx;
                        busy_d     = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            hold_cnt_q   <= '0;
            turn_cnt_q   <= '0;
            last_owner_q <= IDW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            hold_cnt_q   <= hold_cnt_d;
            turn_cnt_q   <= turn_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_xup_tri_bus_arbiter.sv
// Scoreboard bench for xup_tri_bus_arbiter (NUM_REQ=4, MAX_HOLD=8, TURN_CYCLES=1).
module tb_xup_tri_bus_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       t;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks;
    int   errors;

    xup_tri_bus_arbiter #(
        .NUM_REQ     (4),
        .MAX_HOLD    (8),
        .TURN_CYCLES (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g,
                        input logic [1:0] o, input logic b, input logic t);
        exp_t e;
        reset = r;
        req   = rq;
        e.g = g;
        e.o = o;
        e.b = b;
        e.t = t;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare every presented output cycle against the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("grant",   int'(grant),   int'(mon_e.g));
            chk("owner",   int'(owner),   int'(mon_e.o));
            chk("busy",    int'(busy),    int'(mon_e.b));
            chk("timeout", int'(timeout), int'(mon_e.t));
            chk("onehot0", int'($countones(grant) <= 1), 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        @(negedge clk);

        // Reset held with all requests pending.
        repeat (3) step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Full rotation under constant requests: 8-cycle holds, timeout, 1 idle cycle.
        for (int k = 0; k < 5; k++) begin
            repeat (8) step(1'b0, 4'b1111, 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
            step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
        end
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single requester 2, then drop: turnaround, then idle.
        repeat (5) step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner 1 holds while req[3] rises; handover after one idle cycle.
        repeat (3) step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Release on the same edge MAX_HOLD is reached: no timeout pulse.
        repeat (8) step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset mid-grant, then priority restarts at requester 0.
        repeat (2) step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Previous owner re-requesting alone wins again after the gap.
        step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
